// File: rtl/airlock_pkg.sv
// Shared encodings for the airlock chamber controller.
// State codes, service types and a small idle-state helper.
package airlock_pkg;

   typedef enum logic [2:0] {
      EVAC_IDLE  = 3'd0,
      PRESS_IDLE = 3'd1,
      OPEN_OUTER = 3'd2,
      OPEN_INNER = 3'd3,
      FILL       = 3'd4,
      DRAIN      = 3'd5
   } state_t;

   localparam logic SVC_ARRIVE = 1'b0;
   localparam logic SVC_DEPART = 1'b1;

   function automatic logic is_idle(state_t s);
      return (s == EVAC_IDLE) || (s == PRESS_IDLE);
   endfunction

endpackage

// File: rtl/airlock_door_timer.sv
// Door-open countdown: load on port entry, hold while blocked.
// zero is high once the countdown has run out.
module door_timer #(
   parameter  int TICKS = 4,
   localparam int TW    = $clog2(TICKS + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic hold,
   output logic zero
);

   logic [TW-1:0] count;

   // load wins; otherwise count down unless blocked or empty
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= TW'(TICKS - 1);
      end else if (!hold && (count != '0)) begin
         count <= count - TW'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: arbitrates arrivals/departures
// and steps ports and pumps with pressure interlocks.
module airlock_sequencer
   import airlock_pkg::*;
#(
   parameter  int DOOR_TICKS = 4,
   parameter  int PRESS_MAX  = 3,
   localparam int PW         = $clog2(PRESS_MAX + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          arrive_req,
   input  logic          depart_req,
   input  logic          door_block,
   output logic          outer_open,
   output logic          inner_open,
   output logic          pump_fill,
   output logic          pump_drain,
   output logic [PW-1:0] press_lvl,
   output logic          busy,
   output logic [2:0]    state_code,
   output logic          done
);

   localparam logic [PW-1:0] P_MAX = PW'(PRESS_MAX);

   state_t        state;
   state_t        state_nxt;
   logic          svc;
   logic          svc_nxt;
   logic          arr_pend;
   logic          dep_pend;
   logic          arr_nxt;
   logic          dep_nxt;
   logic          arr_eff;
   logic          dep_eff;
   logic [PW-1:0] press_nxt;
   logic          tmr_load;
   logic          tmr_zero;
   logic          door_exit;

   door_timer #(
      .TICKS (DOOR_TICKS)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .load  (tmr_load),
      .hold  (door_block),
      .zero  (tmr_zero)
   );

   // next state, pending flags and pressure from current state
   always_comb begin
      arr_eff   = arr_pend | arrive_req;
      dep_eff   = dep_pend | depart_req;
      door_exit = tmr_zero && !door_block;
      state_nxt = state;
      svc_nxt   = svc;
      arr_nxt   = arr_eff;
      dep_nxt   = dep_eff;
      unique case (state)
         EVAC_IDLE: begin
            if (arr_eff) begin
               state_nxt = OPEN_OUTER;
               svc_nxt   = SVC_ARRIVE;
               arr_nxt   = 1'b0;
            end else if (dep_eff) begin
               state_nxt = FILL;
               svc_nxt   = SVC_DEPART;
               dep_nxt   = 1'b0;
            end
         end
         PRESS_IDLE: begin
            if (dep_eff) begin
               state_nxt = OPEN_INNER;
               svc_nxt   = SVC_DEPART;
               dep_nxt   = 1'b0;
            end else if (arr_eff) begin
               state_nxt = DRAIN;
               svc_nxt   = SVC_ARRIVE;
               arr_nxt   = 1'b0;
            end
         end
         OPEN_OUTER: begin
            if (door_exit) begin
               state_nxt = (svc == SVC_ARRIVE) ?
                           FILL : EVAC_IDLE;
            end
         end
         OPEN_INNER: begin
            if (door_exit) begin
               state_nxt = (svc == SVC_ARRIVE) ?
                           PRESS_IDLE : DRAIN;
            end
         end
         FILL: begin
            if (press_lvl == P_MAX) state_nxt = OPEN_INNER;
         end
         DRAIN: begin
            if (press_lvl == '0) state_nxt = OPEN_OUTER;
         end
         default: state_nxt = EVAC_IDLE;
      endcase

      press_nxt = press_lvl;
      if ((state_nxt == FILL) && (press_lvl != P_MAX))
         press_nxt = press_lvl + PW'(1);
      else if ((state_nxt == DRAIN) && (press_lvl != '0))
         press_nxt = press_lvl - PW'(1);

      tmr_load = (state_nxt != state) &&
                 ((state_nxt == OPEN_OUTER) ||
                  (state_nxt == OPEN_INNER));
   end

   // register state and every output from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= EVAC_IDLE;
         svc        <= SVC_ARRIVE;
         arr_pend   <= 1'b0;
         dep_pend   <= 1'b0;
         press_lvl  <= '0;
         outer_open <= 1'b0;
         inner_open <= 1'b0;
         pump_fill  <= 1'b0;
         pump_drain <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         svc        <= svc_nxt;
         arr_pend   <= arr_nxt;
         dep_pend   <= dep_nxt;
         press_lvl  <= press_nxt;
         outer_open <= (state_nxt == OPEN_OUTER);
         inner_open <= (state_nxt == OPEN_INNER);
         pump_fill  <= (state_nxt == FILL);
         pump_drain <= (state_nxt == DRAIN);
         busy       <= !is_idle(state_nxt);
         done       <= !is_idle(state) && is_idle(state_nxt);
      end
   end

   assign state_code = state;

   a_outer_vac: assert property (@(posedge clock)
      disable iff (reset) outer_open |-> (press_lvl == '0));
   a_inner_full: assert property (@(posedge clock)
      disable iff (reset) inner_open |-> (press_lvl == P_MAX));
   a_pump_port: assert property (@(posedge clock)
      disable iff (reset)
      (pump_fill || pump_drain) |-> !(outer_open || inner_open));
   a_two_pumps: assert property (@(posedge clock)
      disable iff (reset) !(pump_fill && pump_drain));
   a_two_ports: assert property (@(posedge clock)
      disable iff (reset) !(outer_open && inner_open));

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: step-list reference model,
// per-cycle output compare and a done-pulse scoreboard.
module tb_airlock_sequencer;

   localparam int DOOR = 4;
   localparam int PMAX = 3;
   localparam int S_EVAC  = 0;
   localparam int S_PRESS = 1;
   localparam int S_OO    = 2;
   localparam int S_OI    = 3;
   localparam int S_FILL  = 4;
   localparam int S_DRAIN = 5;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       arrive_req = 1'b0;
   logic       depart_req = 1'b0;
   logic       door_block = 1'b0;
   logic       outer_open;
   logic       inner_open;
   logic       pump_fill;
   logic       pump_drain;
   logic [1:0] press_lvl;
   logic       busy;
   logic [2:0] state_code;
   logic       done;

   airlock_sequencer #(
      .DOOR_TICKS (DOOR),
      .PRESS_MAX  (PMAX)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .arrive_req (arrive_req),
      .depart_req (depart_req),
      .door_block (door_block),
      .outer_open (outer_open),
      .inner_open (inner_open),
      .pump_fill  (pump_fill),
      .pump_drain (pump_drain),
      .press_lvl  (press_lvl),
      .busy       (busy),
      .state_code (state_code),
      .done       (done)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_fail = 0;

   int m_cur = S_EVAC;
   int m_tick = 0;
   int m_press = 0;
   int m_final = S_EVAC;
   bit m_arr = 1'b0;
   bit m_dep = 1'b0;
   bit m_done = 1'b0;
   int m_steps[$];
   int sb[$];
   int n_start = 0;
   int n_done = 0;

   int c_outer, c_inner, c_fill, c_drain, c_done, c_bad;
   int pseq;

   task automatic check(input string tag,
                        input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic bit m_idle();
      return (m_cur == S_EVAC) || (m_cur == S_PRESS);
   endfunction

   function automatic int pack(bit o, bit i, bit f, bit d,
                               bit b, bit dn, int st, int p);
      return int'({o, i, f, d, b, dn}) * 32 + st * 4 + p;
   endfunction

   task automatic enter(input int s);
      m_cur = s;
      if (s == S_OO || s == S_OI) m_tick = DOOR - 1;
      else if (s == S_FILL && m_press < PMAX) m_press++;
      else if (s == S_DRAIN && m_press > 0) m_press--;
   endtask

   task automatic model(input bit ar, input bit dp,
                        input bit blk, input bit rs);
      bit ea, ed, fin;
      if (rs) begin
         m_cur = S_EVAC; m_press = 0; m_tick = 0;
         m_arr = 0; m_dep = 0; m_done = 0;
         m_steps.delete(); sb.delete();
         return;
      end
      ea = m_arr | ar;
      ed = m_dep | dp;
      m_done = 0;
      if (m_idle()) begin
         if (m_cur == S_PRESS) begin
            if (ed) begin
               ed = 0; m_final = S_EVAC;
               m_steps = '{S_OI, S_DRAIN, S_OO};
            end else if (ea) begin
               ea = 0; m_final = S_PRESS;
               m_steps = '{S_DRAIN, S_OO, S_FILL, S_OI};
            end
         end else begin
            if (ea) begin
               ea = 0; m_final = S_PRESS;
               m_steps = '{S_OO, S_FILL, S_OI};
            end else if (ed) begin
               ed = 0; m_final = S_EVAC;
               m_steps = '{S_FILL, S_OI, S_DRAIN, S_OO};
            end
         end
         if (m_steps.size() > 0) begin
            sb.push_back(m_final);
            n_start++;
            enter(m_steps.pop_front());
         end
      end else begin
         if (m_cur == S_FILL) fin = (m_press == PMAX);
         else if (m_cur == S_DRAIN) fin = (m_press == 0);
         else fin = (m_tick == 0) && !blk;
         if (fin) begin
            if (m_steps.size() == 0) begin
               m_cur = m_final;
               m_done = 1;
            end else begin
               enter(m_steps.pop_front());
            end
         end else if (m_cur == S_FILL) begin
            if (m_press < PMAX) m_press++;
         end else if (m_cur == S_DRAIN) begin
            if (m_press > 0) m_press--;
         end else if (!blk && m_tick > 0) begin
            m_tick--;
         end
      end
      m_arr = ea;
      m_dep = ed;
   endtask

   task automatic sample();
      int got, exp, want;
      got = pack(outer_open, inner_open, pump_fill,
                 pump_drain, busy, done,
                 int'(state_code), int'(press_lvl));
      exp = pack(m_cur == S_OO, m_cur == S_OI,
                 m_cur == S_FILL, m_cur == S_DRAIN,
                 !m_idle(), m_done, m_cur, m_press);
      check("cycle", got, exp);
      c_outer += int'(outer_open);
      c_inner += int'(inner_open);
      c_fill  += int'(pump_fill);
      c_drain += int'(pump_drain);
      c_done  += int'(done);
      if (pump_fill || pump_drain)
         pseq = pseq * 10 + int'(press_lvl);
      if (outer_open && press_lvl != 2'd0) c_bad++;
      if (inner_open && int'(press_lvl) != PMAX) c_bad++;
      if (done) begin
         n_done++;
         want = (sb.size() == 0) ? -1 : sb.pop_front();
         check("sb_final", int'(state_code), want);
      end
   endtask

   task automatic step(input bit ar, input bit dp,
                       input bit blk, input bit rs);
      arrive_req = ar;
      depart_req = dp;
      door_block = blk;
      reset      = rs;
      @(posedge clock);
      model(ar, dp, blk, rs);
      #1;
      sample();
      arrive_req = 1'b0;
      depart_req = 1'b0;
      door_block = 1'b0;
      reset      = 1'b0;
   endtask

   task automatic clr();
      c_outer = 0; c_inner = 0; c_fill = 0;
      c_drain = 0; c_done = 0; c_bad = 0; pseq = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0);
   endtask

   initial begin
      clr();
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("rst_state", int'(state_code), S_EVAC);
      check("rst_press", int'(press_lvl), 0);
      check("rst_busy", int'(busy), 0);

      clr();
      step(1, 0, 0, 0);
      idle(16);
      check("t1_outer", c_outer, 4);
      check("t1_fill", c_fill, 3);
      check("t1_press", pseq, 123);
      check("t1_inner", c_inner, 4);
      check("t1_done", c_done, 1);
      check("t1_state", int'(state_code), S_PRESS);

      clr();
      step(0, 1, 0, 0);
      idle(16);
      check("t2_inner", c_inner, 4);
      check("t2_drain", c_drain, 3);
      check("t2_press", pseq, 210);
      check("t2_outer", c_outer, 4);
      check("t2_done", c_done, 1);
      check("t2_state", int'(state_code), S_EVAC);

      clr();
      step(1, 1, 0, 0);
      idle(36);
      check("t3_outer", c_outer, 8);
      check("t3_inner", c_inner, 8);
      check("t3_fill", c_fill, 3);
      check("t3_drain", c_drain, 3);
      check("t3_done", c_done, 2);
      check("t3_state", int'(state_code), S_EVAC);

      clr();
      step(1, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 1, 0);
      idle(20);
      check("t4_outer", c_outer, 7);
      check("t4_bad", c_bad, 0);
      check("t4_done", c_done, 1);

      clr();
      step(0, 0, 0, 1);
      step(1, 0, 0, 0);
      for (int k = 0; k < 30; k++) begin
         if (m_cur == S_FILL && m_press == 2) break;
         step(0, k == 1, 0, 0);
      end
      check("t5_lvl", int'(press_lvl), 2);
      check("t5_fill", int'(pump_fill), 1);
      step(0, 0, 0, 1);
      check("t5_rst", pack(outer_open, inner_open,
            pump_fill, pump_drain, busy, done,
            int'(state_code), int'(press_lvl)), 0);
      idle(5);
      check("t5_nopend", int'(busy), 0);

      n_start = 0;
      n_done = 0;
      clr();
      for (int k = 0; k < 2000; k++)
         step($urandom_range(15) == 0,
              $urandom_range(15) == 0,
              $urandom_range(3) == 0, 0);
      for (int k = 0; k < 400; k++) begin
         if (m_idle() && !m_arr && !m_dep) break;
         step(0, 0, 0, 0);
      end
      idle(2);
      check("q_busy", int'(busy), 0);
      check("q_done", n_done, n_start);
      check("q_sb", sb.size(), 0);
      check("q_bad", c_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               n_chk, n_fail);
      $finish;
   end

endmodule
